y_pipe_reg: RTL
===============

// Module: y_pipe_reg
// PURPOSE
//   Parametrised elastic successor of the single ALU Y result register.
//   DEPTH-stage register pipeline, valid/ready handshake both sides, synchronous flush, occupancy count.
//   Sits between the ALU result mux and the writeback/consumer stage.
//   Lets the Y path absorb consumer back-pressure without losing or duplicating results.
// PARAMETERS
//   WIDTH  32  data width of each Y result
//   DEPTH  2   number of pipeline stages (legal range 1..8)
//   CNT_W  $clog2(DEPTH+1)  occupancy counter width (derived, localparam)
// PORTS
//   clk        in   1      rising-edge clock
//   rst        in   1      asynchronous, active-low reset (0 = reset)
//   flush      in   1      synchronous pipeline flush, active-high
//   in_valid   in   1      upstream result valid
//   in_ready   out  1      pipeline can accept in_data this cycle
//   in_data    in   WIDTH  ALU Y result
//   out_valid  out  1      stage DEPTH-1 holds a valid result
//   out_ready  in   1      downstream accepts out_data this cycle
//   out_data   out  WIDTH  result at the last stage
//   occupancy  out  CNT_W  number of valid stages, 0..DEPTH
// BEHAVIOUR
//   Reset (rst=0, async): all stage data <= 0, all stage valids <= 0.
//     Outputs during/after reset: out_data=0, out_valid=0, occupancy=0, in_ready=1.
//   Stages: 0 (input side) .. DEPTH-1 (output side). Each stage has data[i] and v[i].
//   Per-stage ready (combinational):
//     rdy[DEPTH-1] = !v[DEPTH-1] | out_ready
//     rdy[i] = !v[i] | rdy[i+1]
//   in_ready = rdy[0] & !flush.
//   Transfers:
//     Input transfer when in_valid & in_ready.
//     Output transfer when out_valid & out_ready.
//   Per clock edge (no flush), stage i with rdy[i]=1 loads:
//     From stage i-1: v[i] <= v[i-1]; data[i] <= data[i-1] only when v[i-1]=1.
//     Stage 0 loads from in_data/in_valid the same way.
//   Stage with rdy[i]=0 holds data and valid (stall); no bubble is inserted behind a stalled stage.
//   Latency: into an empty pipe with out_ready=1, a result accepted at edge N shows out_valid=1
//     after edge N+DEPTH-1 (DEPTH register stages, first load at edge N).
//   Throughput: 1 result/cycle sustained while out_ready=1.
//   Full: occupancy=DEPTH and out_ready=0 -> in_ready=0.
//   Full with out_ready=1: simultaneous accept and emit allowed; occupancy unchanged.
//   Empty: out_valid=0; out_data holds the last value (not cleared).
//   Ordering: strict FIFO. No drop, no duplication.
//   Flush (sync, priority over all transfers): next edge all v[i] <= 0, occupancy <= 0; data regs untouched.
//     in_ready=0 during the flush cycle.
//     An output transfer in the flush cycle still counts as consumed downstream.
//   occupancy: registered.
//     +1 on input transfer only; -1 on output transfer only; unchanged when both or neither.
//     0 on flush or reset.
//   Reset mid-operation: async clear regardless of handshake state; stalled data is discarded.
//   Downstream must not depend on out_data while out_valid=0.
//   Upstream may drop in_valid freely while in_ready=0 (no hold requirement enforced).
// TESTING (WIDTH=32, DEPTH=3)
//   Reset: rst=0 mid-stream with 2 results held -> immediately out_valid=0, out_data=0, occupancy=0, in_ready=1.
//   Latency/stream: out_ready=1, push 0x11,0x22,0x33 on consecutive cycles -> out_valid at edge 3;
//     outputs 0x11,0x22,0x33 back-to-back.
//   Back-pressure: out_ready=0, push 0xA0..0xA3 -> 3 accepted, occupancy=3, in_ready=0 on the 4th;
//     release out_ready -> 0xA0,0xA1,0xA2 in order, then 0xA3 once re-offered.
//   Full pass-through: occupancy=3, in_valid=1 and out_ready=1 together for 5 cycles -> occupancy stays 3, no loss.
//   Flush: occupancy=2, assert flush with in_valid=1 data 0xFF -> in_ready=0; next cycle occupancy=0, out_valid=0; 0xFF never emitted.
//   Bubble: alternate in_valid 1/0 with out_ready toggling pseudo-randomly (1000 cycles) -> scoreboard matches in order;
//     occupancy never exceeds 3.

Source files
------------

// File: rtl/y_pipe_reg.sv
// y_pipe_reg: elastic DEPTH-stage pipeline for ALU Y results.
// Valid/ready handshake on both sides, synchronous flush and a registered
// occupancy count. Stalled stages hold their contents. A stage only moves
// forward when the stage ahead of it can take the result, so nothing is
// dropped or duplicated.
module y_pipe_reg #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] data_q    [DEPTH];
  logic [DEPTH-1:0] v_q;
  logic [DEPTH-1:0] rdy;
  logic [DEPTH-1:0] prev_v;
  logic [WIDTH-1:0] prev_data [DEPTH];
  logic             in_fire;
  logic             out_fire;

  // Ready chain: a stage can load if it is empty or everything ahead of it can move.
  always_comb begin
    logic chain;
    chain = !v_q[DEPTH-1] | out_ready;
    rdy   = '0;
    rdy[DEPTH-1] = chain;
    for (int i = DEPTH-2; i >= 0; i--) begin
      chain  = !v_q[i] | chain;
      rdy[i] = chain;
    end
  end

  // Source of each stage: upstream input for stage 0, the previous stage otherwise.
  always_comb begin
    prev_v       = '0;
    prev_v[0]    = in_valid;
    prev_data[0] = in_data;
    for (int i = 1; i < DEPTH; i++) begin
      prev_v[i]    = v_q[i-1];
      prev_data[i] = data_q[i-1];
    end
  end

  assign in_ready  = rdy[0] & !flush;
  assign out_valid = v_q[DEPTH-1];
  assign out_data  = data_q[DEPTH-1];
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  // Stage registers: flush clears the valids only; data is captured only from a valid source.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
      end
    end else if (flush) begin
      v_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (rdy[i]) begin
          v_q[i] <= prev_v[i];
          if (prev_v[i]) begin
            data_q[i] <= prev_data[i];
          end
        end
      end
    end
  end

  // Occupancy tracks accepted minus emitted results; a simultaneous accept and emit leaves it unchanged.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      occupancy <= '0;
    end else if (flush) begin
      occupancy <= '0;
    end else begin
      case ({in_fire, out_fire})
        2'b10:   occupancy <= occupancy + CNT_W'(1);
        2'b01:   occupancy <= occupancy - CNT_W'(1);
        default: occupancy <= occupancy;
      endcase
    end
  end

endmodule
